branch_resolve_unit: RTL and testbench
======================================

// Module: branch_resolve_unit
// PURPOSE
// - Decode-stage branch resolution for the 5-stage MIPS pipeline, parametrised in data/PC width.
// - Resolves beq/bne/blez/bgtz/bltz/bgez/jal/jr and registers the outcome for the PC-select stage.
// - Keeps a 2-bit branch history table read by Fetch; flags mispredicts and counts branches.
// PARAMETERS
// - DATA_W     32  operand width for rd1/rd2
// - PC_W       32  program-counter and target width
// - BHT_DEPTH  64  history-table entries; power of two, >=2
// - CNT_W      16  width of statistics counters
// PORTS
// - clk             in   1       pipeline clock, rising edge
// - reset_n         in   1       asynchronous, active-low reset
// - f_pc            in   PC_W    Fetch PC for prediction lookup
// - f_pred_taken    out  1       prediction for f_pc (combinational)
// - req_valid       in   1       D-stage request present
// - req_ready       out  1       request accepted this cycle when high with req_valid
// - req_pc          in   PC_W    PC of the instruction being resolved
// - req_op          in   4       jump op code (shared encoding)
// - req_rd1/req_rd2 in   DATA_W  forwarded operands
// - req_target      in   PC_W    precomputed branch/jal target
// - req_pred_taken  in   1       prediction carried down from Fetch
// - res_valid       out  1       registered result valid
// - res_ready       in   1       consumer takes result when high with res_valid
// - res_next_op     out  4       0 PC+4, 1 branch target, 2 jal target, 3 jr (rd1)
// - res_link        out  1       write $ra (jal only)
// - res_taken       out  1       resolved direction
// - res_mispredict  out  1       Fetch must flush and redirect
// - res_target      out  PC_W    redirect address (req_target, rd1 for jr, req_pc+4 otherwise)
// - cnt_branch      out  CNT_W   accepted conditional branches
// - cnt_mispredict  out  CNT_W   accepted mispredicted conditional branches
// BEHAVIOUR
// - Reset (async, reset_n low): res_valid, res_*, cnt_* = 0; every BHT entry = 2'b01 (weak not-taken).
// - req_ready = !res_valid || res_ready. Accept = req_valid && req_ready.
// - Latency: 1 cycle. On accept, result registers load and res_valid=1 next edge; else if res_ready, res_valid=0.
// - Stall: res_valid && !res_ready -> all res_* held stable, req_ready=0, no BHT or counter update.
// - Ops: 0 none; 1 beq (rd1==rd2); 2 bne; 3 jal; 4 jr; 5 blez; 6 bgtz; 7 bltz; 8 bgez.
// - Ops 5-8 compare rd1 signed against 0. Codes 9-15 are treated as none.
// - Equality covers all DATA_W bits; X/Z is not special-cased.
// - Taken cond -> next_op 1. jal -> next_op 2, link 1, taken 1. jr -> next_op 3, target = rd1[PC_W-1:0].
// - Not taken / none -> next_op 0, target = req_pc+4 (wraps modulo 2^PC_W).
// - Mispredict: cond ops only, = taken ^ req_pred_taken; 0 for jal/jr/none.
// - BHT index = pc[$clog2(BHT_DEPTH)+1:2], so word-aligned PCs alias modulo depth.
// - BHT update on accept of a cond op: taken -> +1 saturating at 3; not taken -> -1 saturating at 0.
// - f_pred_taken = entry[f_pc idx][1]. Same-cycle update to the same index: lookup returns the pre-update value.
// - Counters increment on accept, saturate at all-ones, never wrap.
// - Reset asserted mid-stall: pending result is discarded; no update is committed.
// CONFIGURATION
// - BRU_PREDICT_EN defined: BHT instantiated; behaves as above.
// - BRU_PREDICT_EN undefined: no table; f_pred_taken=0 (static not-taken); mispredict = taken for cond ops.
//   All ports remain present in both builds.
// STRUCTURE
// - Shared package/header bru_pkg: jump op codes (JUMP_NONE..JUMP_BGEZ), next_op codes (NPC_SEQ, NPC_BR, NPC_JAL, NPC_JR), BHT reset constant 2'b01.
// - Sub-module bru_bht: BHT_DEPTH x 2-bit table; 1 async read port, 1 write port with saturating update, async reset.
// - Top level: compare/decode logic, result register with valid/ready, statistics counters.
// TESTING
// - Reset, then beq rd1=rd2=0x1234, pred=0, target=0x3010 -> next cycle res_valid=1, next_op=1, taken=1, mispredict=1, target=0x3010, cnt_mispredict=1.
// - bgez rd1=0x80000000 and blez rd1=0 (pred 0 each) -> not taken (next_op 0, target=pc+4) then taken; signedness confirmed.
// - Same pc=0x40 branch taken 3x: f_pc=0x40 pred goes 0,1,1; entry saturates at 3. Then 3 not-taken -> pred 0, entry saturates at 0.
// - Hold res_ready=0 for 4 cycles with req_valid=1 -> req_ready=0, res_* stable, cnt_branch unchanged. Release -> exactly one accept per cycle.
// - jal target=0x400 -> next_op=2, link=1, mispredict=0. jr rd1=0x1F0 -> next_op=3, target=0x1F0. req_pc=0xFFFFFFFC, op none -> target 0x0.
// - Preload cnt_branch to 0xFFFF via repeated branches -> stays 0xFFFF. Pulse reset_n low mid-stall -> res_valid=0 immediately, BHT back to 01.

Source files
------------

// File: rtl/bru_pkg.sv
// bru_pkg: shared encodings and helpers for the branch resolve unit.
// Jump op codes, next-PC select codes, BHT reset value and the 2-bit
// saturating counter update used by the history table.
package bru_pkg;

  typedef enum logic [3:0] {
    JUMP_NONE = 4'd0,
    JUMP_BEQ  = 4'd1,
    JUMP_BNE  = 4'd2,
    JUMP_JAL  = 4'd3,
    JUMP_JR   = 4'd4,
    JUMP_BLEZ = 4'd5,
    JUMP_BGTZ = 4'd6,
    JUMP_BLTZ = 4'd7,
    JUMP_BGEZ = 4'd8
  } jump_op_e;

  typedef enum logic [3:0] {
    NPC_SEQ = 4'd0,
    NPC_BR  = 4'd1,
    NPC_JAL = 4'd2,
    NPC_JR  = 4'd3
  } npc_e;

  // Every history entry starts as weak not-taken.
  localparam logic [1:0] BHT_RESET = 2'b01;

  // Two-bit saturating counter step: taken counts up to 3, not-taken down to 0.
  function automatic logic [1:0] bhtNext(input logic [1:0] cur, input logic taken);
    logic [1:0] nxt;
    nxt = cur;
    if (taken && (cur != 2'b11)) begin
      nxt = cur + 2'b01;
    end else if (!taken && (cur != 2'b00)) begin
      nxt = cur - 2'b01;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/bru_bht.sv
// bru_bht: branch history table, DEPTH x 2-bit saturating counters.
// One asynchronous read port (Fetch lookup) and one write port that applies
// the saturating update in place. A lookup of an index being written in the
// same cycle sees the old entry, since the write lands on the clock edge.
module bru_bht
  import bru_pkg::*;
#(
  parameter int DEPTH = 64,
  parameter int IDX_W = $clog2(DEPTH)
) (
  input  logic             clk_i,
  input  logic             reset_n_i,
  input  logic [IDX_W-1:0] rdIdx_i,
  output logic             rdTaken_o,
  input  logic             wrEn_i,
  input  logic [IDX_W-1:0] wrIdx_i,
  input  logic             wrTaken_i
);

  logic [1:0] entries_q [DEPTH];

  // The prediction is the counter's upper bit: 2 and 3 mean taken.
  assign rdTaken_o = entries_q[rdIdx_i][1];

  // Table storage: reset every entry to weak not-taken, otherwise step the written entry.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        entries_q[i] <= BHT_RESET;
      end
    end else if (wrEn_i) begin
      entries_q[wrIdx_i] <= bhtNext(entries_q[wrIdx_i], wrTaken_i);
    end
  end

endmodule

// File: rtl/branch_resolve_unit.sv
// branch_resolve_unit: decode-stage branch resolution for the 5-stage MIPS pipe.
// Resolves beq/bne/blez/bgtz/bltz/bgez/jal/jr, registers the outcome behind a
// valid/ready handshake, counts branches and mispredicts (saturating).
// Optional macro BRU_PREDICT_EN: when defined a 2-bit BHT (bru_bht) drives
// f_pred_taken and mispredict compares against the carried prediction; when
// undefined prediction is static not-taken and every taken branch mispredicts.
module branch_resolve_unit
  import bru_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int PC_W      = 32,
  parameter int BHT_DEPTH = 64,
  parameter int CNT_W     = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [PC_W-1:0]   f_pc,
  output logic              f_pred_taken,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [PC_W-1:0]   req_pc,
  input  logic [3:0]        req_op,
  input  logic [DATA_W-1:0] req_rd1,
  input  logic [DATA_W-1:0] req_rd2,
  input  logic [PC_W-1:0]   req_target,
  input  logic              req_pred_taken,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [3:0]        res_next_op,
  output logic              res_link,
  output logic              res_taken,
  output logic              res_mispredict,
  output logic [PC_W-1:0]   res_target,
  output logic [CNT_W-1:0]  cnt_branch,
  output logic [CNT_W-1:0]  cnt_mispredict
);

  localparam int IDX_W = $clog2(BHT_DEPTH);

  logic              accept;
  logic              rd1Eq;
  logic              rd1Neg;
  logic              rd1Zero;
  logic [PC_W-1:0]   seqPc;
  logic [PC_W-1:0]   jrTarget;

  logic              isCond;
  logic              decTaken;
  logic              decLink;
  logic              decMispredict;
  logic [3:0]        decNextOp;
  logic [PC_W-1:0]   decTarget;

  logic              resValid_q,   resValid_d;
  logic [3:0]        resNextOp_q,  resNextOp_d;
  logic              resLink_q,    resLink_d;
  logic              resTaken_q,   resTaken_d;
  logic              resMis_q,     resMis_d;
  logic [PC_W-1:0]   resTarget_q,  resTarget_d;
  logic [CNT_W-1:0]  cntBranch_q,  cntBranch_d;
  logic [CNT_W-1:0]  cntMis_q,     cntMis_d;

  // A new request can enter whenever the output slot is empty or being drained.
  assign req_ready = !resValid_q || res_ready;
  assign accept    = req_valid && req_ready;

  // Operand comparisons; the sign bit of rd1 gives the signed test against zero.
  assign rd1Eq   = (req_rd1 == req_rd2);
  assign rd1Neg  = req_rd1[DATA_W-1];
  assign rd1Zero = (req_rd1 == '0);
  assign seqPc   = req_pc + PC_W'(4);

  generate
    if (DATA_W >= PC_W) begin : g_jrSlice
      assign jrTarget = req_rd1[PC_W-1:0];
    end else begin : g_jrExtend
      assign jrTarget = {{(PC_W - DATA_W){1'b0}}, req_rd1};
    end
  endgenerate

  // Decode the op into direction, next-PC select, link and redirect target.
  always_comb begin
    isCond    = 1'b0;
    decTaken  = 1'b0;
    decLink   = 1'b0;
    decNextOp = NPC_SEQ;
    decTarget = seqPc;
    case (req_op)
      JUMP_BEQ:  begin isCond = 1'b1; decTaken = rd1Eq; end
      JUMP_BNE:  begin isCond = 1'b1; decTaken = !rd1Eq; end
      JUMP_BLEZ: begin isCond = 1'b1; decTaken = rd1Neg || rd1Zero; end
      JUMP_BGTZ: begin isCond = 1'b1; decTaken = !rd1Neg && !rd1Zero; end
      JUMP_BLTZ: begin isCond = 1'b1; decTaken = rd1Neg; end
      JUMP_BGEZ: begin isCond = 1'b1; decTaken = !rd1Neg; end
      JUMP_JAL: begin
        decTaken  = 1'b1;
        decLink   = 1'b1;
        decNextOp = NPC_JAL;
        decTarget = req_target;
      end
      JUMP_JR: begin
        decTaken  = 1'b1;
        decNextOp = NPC_JR;
        decTarget = jrTarget;
      end
      default: begin
        isCond = 1'b0;
      end
    endcase
    if (isCond && decTaken) begin
      decNextOp = NPC_BR;
      decTarget = req_target;
    end
  end

`ifdef BRU_PREDICT_EN
  logic bhtPred;
  logic unusedInputs;

  // Fetch only uses the index bits of its PC.
  assign unusedInputs = ^{f_pc};

  bru_bht #(
    .DEPTH (BHT_DEPTH),
    .IDX_W (IDX_W)
  ) u_bht (
    .clk_i     (clk),
    .reset_n_i (reset_n),
    .rdIdx_i   (f_pc[IDX_W+1:2]),
    .rdTaken_o (bhtPred),
    .wrEn_i    (accept && isCond),
    .wrIdx_i   (req_pc[IDX_W+1:2]),
    .wrTaken_i (decTaken)
  );

  assign f_pred_taken  = bhtPred;
  assign decMispredict = isCond && (decTaken ^ req_pred_taken);
`else
  logic unusedInputs;

  // Static not-taken: the Fetch PC and the carried prediction play no part.
  assign unusedInputs  = ^{f_pc, req_pred_taken};
  assign f_pred_taken  = 1'b0;
  assign decMispredict = isCond && decTaken;
`endif

  // Next state of the result slot and the saturating statistics counters.
  always_comb begin
    resValid_d  = resValid_q;
    resNextOp_d = resNextOp_q;
    resLink_d   = resLink_q;
    resTaken_d  = resTaken_q;
    resMis_d    = resMis_q;
    resTarget_d = resTarget_q;
    cntBranch_d = cntBranch_q;
    cntMis_d    = cntMis_q;
    if (accept) begin
      resValid_d  = 1'b1;
      resNextOp_d = decNextOp;
      resLink_d   = decLink;
      resTaken_d  = decTaken;
      resMis_d    = decMispredict;
      resTarget_d = decTarget;
      if (isCond && (cntBranch_q != '1)) begin
        cntBranch_d = cntBranch_q + CNT_W'(1);
      end
      if (decMispredict && (cntMis_q != '1)) begin
        cntMis_d = cntMis_q + CNT_W'(1);
      end
    end else if (res_ready) begin
      resValid_d = 1'b0;
    end
  end

  // Result and counter registers; async reset drops any pending result.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      resValid_q  <= 1'b0;
      resNextOp_q <= '0;
      resLink_q   <= 1'b0;
      resTaken_q  <= 1'b0;
      resMis_q    <= 1'b0;
      resTarget_q <= '0;
      cntBranch_q <= '0;
      cntMis_q    <= '0;
    end else begin
      resValid_q  <= resValid_d;
      resNextOp_q <= resNextOp_d;
      resLink_q   <= resLink_d;
      resTaken_q  <= resTaken_d;
      resMis_q    <= resMis_d;
      resTarget_q <= resTarget_d;
      cntBranch_q <= cntBranch_d;
      cntMis_q    <= cntMis_d;
    end
  end

  assign res_valid      = resValid_q;
  assign res_next_op    = resNextOp_q;
  assign res_link       = resLink_q;
  assign res_taken      = resTaken_q;
  assign res_mispredict = resMis_q;
  assign res_target     = resTarget_q;
  assign cnt_branch     = cntBranch_q;
  assign cnt_mispredict = cntMis_q;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// tb_branch_resolve_unit: directed self-checking bench for branch_resolve_unit.
// Expectations follow the build: with BRU_PREDICT_EN the BHT predictions are
// expected, otherwise static not-taken. Counters are 8 bits wide here.
module tb_branch_resolve_unit;

  localparam int DATA_W = 32;
  localparam int PC_W   = 32;
  localparam int CNT_W  = 8;
`ifdef BRU_PREDICT_EN
  localparam bit PRED_EN = 1'b1;
`else
  localparam bit PRED_EN = 1'b0;
`endif

  typedef struct {
    logic [3:0]  op;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [31:0] pc;
    logic [31:0] target;
    logic        pred;
    logic [3:0]  expNextOp;
    logic        expTaken;
    logic        expMis;
    logic [31:0] expTarget;
  } vec_t;

  logic              clk = 1'b0;
  logic              reset_n;
  logic [PC_W-1:0]   f_pc;
  logic              f_pred_taken;
  logic              req_valid;
  logic              req_ready;
  logic [PC_W-1:0]   req_pc;
  logic [3:0]        req_op;
  logic [DATA_W-1:0] req_rd1;
  logic [DATA_W-1:0] req_rd2;
  logic [PC_W-1:0]   req_target;
  logic              req_pred_taken;
  logic              res_valid;
  logic              res_ready;
  logic [3:0]        res_next_op;
  logic              res_link;
  logic              res_taken;
  logic              res_mispredict;
  logic [PC_W-1:0]   res_target;
  logic [CNT_W-1:0]  cnt_branch;
  logic [CNT_W-1:0]  cnt_mispredict;

  int errors = 0;
  int checks = 0;
  logic [CNT_W-1:0] expBranch = '0;
  logic [CNT_W-1:0] expMis    = '0;

  branch_resolve_unit #(
    .DATA_W    (DATA_W),
    .PC_W      (PC_W),
    .BHT_DEPTH (64),
    .CNT_W     (CNT_W)
  ) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .f_pc           (f_pc),
    .f_pred_taken   (f_pred_taken),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_pc         (req_pc),
    .req_op         (req_op),
    .req_rd1        (req_rd1),
    .req_rd2        (req_rd2),
    .req_target     (req_target),
    .req_pred_taken (req_pred_taken),
    .res_valid      (res_valid),
    .res_ready      (res_ready),
    .res_next_op    (res_next_op),
    .res_link       (res_link),
    .res_taken      (res_taken),
    .res_mispredict (res_mispredict),
    .res_target     (res_target),
    .cnt_branch     (cnt_branch),
    .cnt_mispredict (cnt_mispredict)
  );

  always #5 clk = ~clk;

  // Present one request for a single edge, leave time at edge+1.
  task automatic applyStimulus(input logic [3:0] op, input logic [31:0] rd1, input logic [31:0] rd2,
                               input logic [31:0] pc, input logic [31:0] target, input logic pred);
    req_op = op; req_rd1 = rd1; req_rd2 = rd2; req_pc = pc;
    req_target = target; req_pred_taken = pred; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0; req_op = 4'd0;
  endtask

  task automatic idleCycle();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    #12;
    checks++; if (res_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_res_valid got %0b want 0", res_valid); end
    checks++; if (res_next_op !== 4'd0) begin errors++; $display("[TB] FAIL reset_next_op got %0d want 0", res_next_op); end
    checks++; if (res_target !== 32'h0) begin errors++; $display("[TB] FAIL reset_target got %h want 0", res_target); end
    checks++; if (cnt_branch !== 8'h0 || cnt_mispredict !== 8'h0) begin errors++; $display("[TB] FAIL reset_counters got %h/%h want 0/0", cnt_branch, cnt_mispredict); end
    checks++; if (req_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_req_ready got %0b want 1", req_ready); end
    checks++; if (f_pred_taken !== 1'b0) begin errors++; $display("[TB] FAIL reset_pred got %0b want 0", f_pred_taken); end
    @(posedge clk); #1;
    reset_n = 1'b1;
    idleCycle();
  endtask

  task automatic test_beq();
    applyStimulus(4'd1, 32'h1234, 32'h1234, 32'h3000, 32'h3010, 1'b0);
    expBranch++; expMis++;
    checks++; if (res_valid !== 1'b1) begin errors++; $display("[TB] FAIL beq_valid got %0b want 1", res_valid); end
    checks++; if (res_next_op !== 4'd1 || res_taken !== 1'b1 || res_link !== 1'b0) begin errors++; $display("[TB] FAIL beq_decode got op=%0d taken=%0b link=%0b want 1/1/0", res_next_op, res_taken, res_link); end
    checks++; if (res_mispredict !== 1'b1) begin errors++; $display("[TB] FAIL beq_mispredict got %0b want 1", res_mispredict); end
    checks++; if (res_target !== 32'h3010) begin errors++; $display("[TB] FAIL beq_target got %h want 00003010", res_target); end
    checks++; if (cnt_mispredict !== 8'd1 || cnt_branch !== 8'd1) begin errors++; $display("[TB] FAIL beq_counters got %0d/%0d want 1/1", cnt_branch, cnt_mispredict); end
    idleCycle();
    checks++; if (res_valid !== 1'b0) begin errors++; $display("[TB] FAIL beq_drain got %0b want 0", res_valid); end
  endtask

  task automatic test_signed();
    vec_t v [7];
    v[0] = '{4'd8, 32'h80000000, 32'h0, 32'h100, 32'h200, 1'b0, 4'd0, 1'b0, 1'b0, 32'h104};
    v[1] = '{4'd5, 32'h0, 32'h0, 32'h104, 32'h300, 1'b0, 4'd1, 1'b1, 1'b1, 32'h300};
    v[2] = '{4'd2, 32'h1, 32'h2, 32'h108, 32'h400, 1'b1, 4'd1, 1'b1, !PRED_EN, 32'h400};
    v[3] = '{4'd7, 32'hFFFFFFFF, 32'h0, 32'h10C, 32'h500, 1'b0, 4'd1, 1'b1, 1'b1, 32'h500};
    v[4] = '{4'd6, 32'h0, 32'h0, 32'h110, 32'h600, 1'b1, 4'd0, 1'b0, PRED_EN, 32'h114};
    v[5] = '{4'd6, 32'h1, 32'h0, 32'h114, 32'h700, 1'b0, 4'd1, 1'b1, 1'b1, 32'h700};
    v[6] = '{4'd1, 32'h1, 32'h80000001, 32'h118, 32'h800, 1'b0, 4'd0, 1'b0, 1'b0, 32'h11C};
    for (int i = 0; i < 7; i++) begin
      applyStimulus(v[i].op, v[i].rd1, v[i].rd2, v[i].pc, v[i].target, v[i].pred);
      expBranch++;
      if (v[i].expMis) expMis++;
      checks++; if (res_next_op !== v[i].expNextOp || res_taken !== v[i].expTaken) begin errors++; $display("[TB] FAIL cond%0d_decode got op=%0d taken=%0b want %0d/%0b", i, res_next_op, res_taken, v[i].expNextOp, v[i].expTaken); end
      checks++; if (res_mispredict !== v[i].expMis) begin errors++; $display("[TB] FAIL cond%0d_mispredict got %0b want %0b", i, res_mispredict, v[i].expMis); end
      checks++; if (res_target !== v[i].expTarget) begin errors++; $display("[TB] FAIL cond%0d_target got %h want %h", i, res_target, v[i].expTarget); end
    end
    checks++; if (cnt_branch !== expBranch || cnt_mispredict !== expMis) begin errors++; $display("[TB] FAIL cond_counters got %0d/%0d want %0d/%0d", cnt_branch, cnt_mispredict, expBranch, expMis); end
  endtask

  task automatic test_bht();
    bit takenSeq [9] = '{1, 1, 1, 0, 0, 0, 0, 1, 1};
    bit predSeq  [9] = '{1, 1, 1, 1, 0, 0, 0, 0, 1};
    logic curPred;
    logic expPred;
    f_pc = 32'h40;
    curPred = 1'b0;
    #3;
    checks++; if (f_pred_taken !== 1'b0) begin errors++; $display("[TB] FAIL bht_initial got %0b want 0", f_pred_taken); end
    for (int i = 0; i < 9; i++) begin
      req_op = 4'd1; req_rd1 = 32'h3; req_rd2 = takenSeq[i] ? 32'h3 : 32'h4;
      req_pc = 32'h40; req_target = 32'h80; req_pred_taken = curPred; req_valid = 1'b1;
      #3;
      checks++; if (f_pred_taken !== curPred) begin errors++; $display("[TB] FAIL bht_preupdate%0d got %0b want %0b", i, f_pred_taken, curPred); end
      @(posedge clk); #1;
      req_valid = 1'b0;
      expBranch++;
      if (PRED_EN ? (takenSeq[i] ^ curPred) : takenSeq[i]) expMis++;
      expPred = PRED_EN & predSeq[i];
      checks++; if (f_pred_taken !== expPred) begin errors++; $display("[TB] FAIL bht_step%0d got %0b want %0b", i, f_pred_taken, expPred); end
      curPred = expPred;
    end
    checks++; if (cnt_branch !== expBranch || cnt_mispredict !== expMis) begin errors++; $display("[TB] FAIL bht_counters got %0d/%0d want %0d/%0d", cnt_branch, cnt_mispredict, expBranch, expMis); end
  endtask

  task automatic test_stall();
    res_ready = 1'b1;
    idleCycle();
    res_ready = 1'b0;
    applyStimulus(4'd1, 32'h5, 32'h5, 32'h500, 32'h600, 1'b1);
    expBranch++;
    if (!PRED_EN) expMis++;
    req_op = 4'd2; req_rd1 = 32'h7; req_rd2 = 32'h7; req_pc = 32'h504;
    req_target = 32'h700; req_pred_taken = 1'b0; req_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #3;
      checks++; if (req_ready !== 1'b0 || res_valid !== 1'b1) begin errors++; $display("[TB] FAIL stall%0d_handshake got ready=%0b valid=%0b want 0/1", i, req_ready, res_valid); end
      checks++; if (res_target !== 32'h600 || res_next_op !== 4'd1 || res_mispredict !== !PRED_EN) begin errors++; $display("[TB] FAIL stall%0d_hold got tgt=%h op=%0d mis=%0b", i, res_target, res_next_op, res_mispredict); end
      checks++; if (cnt_branch !== expBranch) begin errors++; $display("[TB] FAIL stall%0d_count got %0d want %0d", i, cnt_branch, expBranch); end
      @(posedge clk); #1;
    end
    res_ready = 1'b1;
    #3;
    checks++; if (req_ready !== 1'b1) begin errors++; $display("[TB] FAIL release_ready got %0b want 1", req_ready); end
    @(posedge clk); #1;
    expBranch++;
    checks++; if (res_target !== 32'h508 || res_next_op !== 4'd0 || cnt_branch !== expBranch) begin errors++; $display("[TB] FAIL release_first got tgt=%h op=%0d cnt=%0d want 508/0/%0d", res_target, res_next_op, cnt_branch, expBranch); end
    req_op = 4'd1; req_rd1 = 32'h9; req_rd2 = 32'h9; req_pc = 32'h508;
    req_target = 32'h800; req_pred_taken = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0; req_op = 4'd0;
    expBranch++;
    if (!PRED_EN) expMis++;
    checks++; if (res_target !== 32'h800 || res_next_op !== 4'd1 || cnt_branch !== expBranch) begin errors++; $display("[TB] FAIL release_second got tgt=%h op=%0d cnt=%0d want 800/1/%0d", res_target, res_next_op, cnt_branch, expBranch); end
    checks++; if (cnt_mispredict !== expMis) begin errors++; $display("[TB] FAIL stall_mispredicts got %0d want %0d", cnt_mispredict, expMis); end
  endtask

  task automatic test_jumps();
    applyStimulus(4'd3, 32'h0, 32'h0, 32'h900, 32'h400, 1'b0);
    checks++; if (res_next_op !== 4'd2 || res_link !== 1'b1 || res_taken !== 1'b1 || res_mispredict !== 1'b0) begin errors++; $display("[TB] FAIL jal_decode got op=%0d link=%0b taken=%0b mis=%0b want 2/1/1/0", res_next_op, res_link, res_taken, res_mispredict); end
    checks++; if (res_target !== 32'h400) begin errors++; $display("[TB] FAIL jal_target got %h want 00000400", res_target); end
    applyStimulus(4'd4, 32'h1F0, 32'h0, 32'h904, 32'hABC, 1'b1);
    checks++; if (res_next_op !== 4'd3 || res_target !== 32'h1F0 || res_link !== 1'b0 || res_mispredict !== 1'b0) begin errors++; $display("[TB] FAIL jr_decode got op=%0d tgt=%h link=%0b mis=%0b want 3/1f0/0/0", res_next_op, res_target, res_link, res_mispredict); end
    applyStimulus(4'd0, 32'h0, 32'h0, 32'hFFFFFFFC, 32'h123, 1'b1);
    checks++; if (res_next_op !== 4'd0 || res_target !== 32'h0 || res_taken !== 1'b0 || res_mispredict !== 1'b0) begin errors++; $display("[TB] FAIL none_wrap got op=%0d tgt=%h taken=%0b mis=%0b want 0/0/0/0", res_next_op, res_target, res_taken, res_mispredict); end
    applyStimulus(4'd12, 32'h5, 32'h5, 32'h200, 32'h999, 1'b0);
    checks++; if (res_next_op !== 4'd0 || res_target !== 32'h204) begin errors++; $display("[TB] FAIL undefined_op got op=%0d tgt=%h want 0/204", res_next_op, res_target); end
    checks++; if (cnt_branch !== expBranch || cnt_mispredict !== expMis) begin errors++; $display("[TB] FAIL jump_counters got %0d/%0d want %0d/%0d", cnt_branch, cnt_mispredict, expBranch, expMis); end
  endtask

  task automatic test_cnt_saturate();
    req_op = 4'd1; req_rd1 = 32'h1; req_rd2 = 32'h1; req_target = 32'h10;
    req_pred_taken = 1'b0; req_valid = 1'b1;
    for (int i = 0; i < 300; i++) begin
      req_pc = 32'h1000 + 32'(i * 4);
      @(posedge clk); #1;
    end
    req_valid = 1'b0; req_op = 4'd0;
    checks++; if (cnt_branch !== 8'hFF) begin errors++; $display("[TB] FAIL sat_branch got %h want ff", cnt_branch); end
    checks++; if (cnt_mispredict !== 8'hFF) begin errors++; $display("[TB] FAIL sat_mispredict got %h want ff", cnt_mispredict); end
  endtask

  task automatic test_reset_mid_stall();
    res_ready = 1'b1;
    idleCycle();
    f_pc = 32'h40;
    res_ready = 1'b0;
    applyStimulus(4'd1, 32'h2, 32'h2, 32'h40, 32'h44, 1'b0);
    req_op = 4'd1; req_rd1 = 32'h2; req_rd2 = 32'h2; req_pc = 32'h40; req_valid = 1'b1;
    checks++; if (res_valid !== 1'b1 || f_pred_taken !== PRED_EN) begin errors++; $display("[TB] FAIL prereset got valid=%0b pred=%0b want 1/%0b", res_valid, f_pred_taken, PRED_EN); end
    #2;
    reset_n = 1'b0;
    #1;
    checks++; if (res_valid !== 1'b0 || req_ready !== 1'b1) begin errors++; $display("[TB] FAIL midreset_valid got valid=%0b ready=%0b want 0/1", res_valid, req_ready); end
    checks++; if (cnt_branch !== 8'h0 || cnt_mispredict !== 8'h0) begin errors++; $display("[TB] FAIL midreset_counters got %h/%h want 0/0", cnt_branch, cnt_mispredict); end
    checks++; if (f_pred_taken !== 1'b0) begin errors++; $display("[TB] FAIL midreset_bht got %0b want 0", f_pred_taken); end
    req_valid = 1'b0; res_ready = 1'b1;
    @(posedge clk); #1;
    reset_n = 1'b1;
    idleCycle();
  endtask

  // Sequence every scenario, then report.
  initial begin
    reset_n = 1'b0; f_pc = '0; req_valid = 1'b0; req_pc = '0; req_op = 4'd0;
    req_rd1 = '0; req_rd2 = '0; req_target = '0; req_pred_taken = 1'b0; res_ready = 1'b1;
    test_reset();
    test_beq();
    test_signed();
    test_bht();
    test_stall();
    test_jumps();
    test_cnt_saturate();
    test_reset_mid_stall();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Guard against a run that never reaches the summary.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired at %0t", $time);
    $fatal(1, "[TB] watchdog");
  end

endmodule
